// File: rtl/instr_fetch_queue.sv
// Fetch stage: issues ROM reads for accepted PCs and queues {instr, pc} for the decoder.
// Optional halt detection is compiled in with `define FETCH_HALT_DETECT_EN.
module instr_fetch_queue #(
    parameter int unsigned    L       = 10,
    parameter int unsigned    W       = 9,
    parameter int unsigned    DEPTH   = 2,
    parameter logic [W-1:0]   HALT_OP = 9'h1FF
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic [L-1:0] FetchAddr,
    input  logic         FetchReq,
    input  logic         Flush,
    output logic         RomEn,
    output logic [L-1:0] RomAddr,
    input  logic [W-1:0] RomData,
    output logic [W-1:0] InstOut,
    output logic [L-1:0] InstPC,
    output logic         InstValid,
    input  logic         InstReady,
    output logic         FetchStall,
    output logic         Halted
);

    localparam int unsigned CW   = $clog2(DEPTH + 1);
    localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OccW = CW + 1;

    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic            inflight_q, inflight_d;
    logic [L-1:0]    inflight_pc_q, inflight_pc_d;
    logic [W-1:0]    mem_inst_q [DEPTH];
    logic [L-1:0]    mem_pc_q   [DEPTH];

    logic            valid, pop, push, stall, accept, halt_block;
    logic [OccW-1:0] occ;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        valid  = (count_q != '0) & ~Flush;
        pop    = valid & InstReady;
        push   = inflight_q & ~Flush;
        // Occupancy after this cycle, counting the read already in flight.
        occ    = {1'b0, count_q} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop};
        stall  = (occ >= OccW'(DEPTH)) | Flush | halt_block;
        accept = FetchReq & ~stall;
    end

`ifdef FETCH_HALT_DETECT_EN
    logic halted_q, halted_d, halt_hit;

    // Stall in the push cycle too, so nothing after the halt is ever fetched.
    assign halt_hit   = push & (RomData == HALT_OP);
    assign halt_block = halted_q | halt_hit;
    assign Halted     = halted_q;

    always_comb begin
        halted_d = halted_q;
        if (Flush) begin
            halted_d = 1'b0;
        end else if (halt_hit) begin
            halted_d = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            halted_q <= 1'b0;
        end else begin
            halted_q <= halted_d;
        end
    end
`else
    logic unused_halt_op;
    assign unused_halt_op = ^HALT_OP;
    assign halt_block     = 1'b0;
    assign Halted         = 1'b0;
`endif

    always_comb begin
        count_d       = count_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        inflight_d    = accept;
        inflight_pc_d = accept ? FetchAddr : inflight_pc_q;
        if (Flush) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            if (push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_inst_q[i] <= '0;
                mem_pc_q[i]   <= '0;
            end
        end else begin
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            if (push) begin
                mem_inst_q[wr_ptr_q] <= RomData;
                mem_pc_q[wr_ptr_q]   <= inflight_pc_q;
            end
        end
    end

    // Outputs are forced low while reset is asserted, independent of the inputs.
    assign RomEn      = accept & Reset;
    assign RomAddr    = Reset ? FetchAddr : '0;
    assign FetchStall = stall & Reset;
    assign InstValid  = valid;
    assign InstOut    = mem_inst_q[rd_ptr_q];
    assign InstPC     = mem_pc_q[rd_ptr_q];

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: queue-based reference model checked every cycle plus directed literals.
module tb_instr_fetch_queue;

    localparam int L     = 10;
    localparam int W     = 9;
    localparam int DEPTH = 2;
    localparam logic [W-1:0] HALT_OP = 9'h1FF;
`ifdef FETCH_HALT_DETECT_EN
    localparam bit HaltEn = 1'b1;
`else
    localparam bit HaltEn = 1'b0;
`endif

    logic         Clk = 1'b0;
    logic         Reset = 1'b0;
    logic [L-1:0] FetchAddr = '0;
    logic         FetchReq = 1'b0;
    logic         Flush = 1'b0;
    logic         RomEn;
    logic [L-1:0] RomAddr;
    logic [W-1:0] RomData = '0;
    logic [W-1:0] InstOut;
    logic [L-1:0] InstPC;
    logic         InstValid;
    logic         InstReady = 1'b0;
    logic         FetchStall;
    logic         Halted;

    instr_fetch_queue dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .FetchAddr  (FetchAddr),
        .FetchReq   (FetchReq),
        .Flush      (Flush),
        .RomEn      (RomEn),
        .RomAddr    (RomAddr),
        .RomData    (RomData),
        .InstOut    (InstOut),
        .InstPC     (InstPC),
        .InstValid  (InstValid),
        .InstReady  (InstReady),
        .FetchStall (FetchStall),
        .Halted     (Halted)
    );

    always #5 Clk = ~Clk;

    logic [W-1:0] rom [1024];
    always @(posedge Clk) if (RomEn) RomData <= rom[RomAddr];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Reference model: FIFO of delivered entries plus the one outstanding ROM read.
    typedef struct packed {
        logic [L-1:0] pc;
        logic [W-1:0] inst;
    } ent_t;

    ent_t         mq[$];
    bit           m_inflight = 0;
    logic [L-1:0] m_ipc = '0;
    bit           m_halted = 0;
    bit           d_live = 0;
    bit           d_pop, d_push, d_accept, d_flush, d_hit;
    logic [W-1:0] d_data;
    logic [L-1:0] d_addr;
    logic [L-1:0] got[$];

    always @(negedge Clk) begin
        bit e_valid, e_pop, e_hit, e_stall, e_accept;
        if (!Reset) begin
            chk("rst_valid", 32'(InstValid), 0);
            chk("rst_romen", 32'(RomEn), 0);
            chk("rst_stall", 32'(FetchStall), 0);
            chk("rst_halted", 32'(Halted), 0);
            chk("rst_pc", 32'(InstPC), 0);
            chk("rst_inst", 32'(InstOut), 0);
            chk("rst_romaddr", 32'(RomAddr), 0);
            d_live = 0;
        end else begin
            e_valid  = (mq.size() != 0) && !Flush;
            e_pop    = e_valid && InstReady;
            e_hit    = HaltEn && m_inflight && !Flush && (RomData == HALT_OP);
            e_stall  = (mq.size() + int'(m_inflight) - int'(e_pop) >= DEPTH) || Flush
                       || m_halted || e_hit;
            e_accept = FetchReq && !e_stall;
            chk("valid", 32'(InstValid), 32'(e_valid));
            if (e_valid) begin
                chk("head_pc", 32'(InstPC), 32'(mq[0].pc));
                chk("head_inst", 32'(InstOut), 32'(mq[0].inst));
            end
            chk("stall", 32'(FetchStall), 32'(e_stall));
            chk("romen", 32'(RomEn), 32'(e_accept));
            if (e_accept) chk("romaddr", 32'(RomAddr), 32'(FetchAddr));
            chk("halted", 32'(Halted), 32'(m_halted));
            if (InstValid && InstReady) got.push_back(InstPC);
            d_pop = e_pop; d_push = m_inflight && !Flush; d_accept = e_accept;
            d_flush = Flush; d_hit = e_hit; d_data = RomData; d_addr = FetchAddr;
            d_live = 1;
        end
    end

    always @(posedge Clk) begin
        if (Reset && d_live) begin
            if (d_flush) begin
                mq.delete();
                m_halted = 0;
            end else begin
                if (d_pop) void'(mq.pop_front());
                if (d_push) mq.push_back('{pc: m_ipc, inst: d_data});
                if (d_hit) m_halted = 1;
            end
            m_inflight = d_accept;
            if (d_accept) m_ipc = d_addr;
        end
    end

    always @(negedge Reset) begin
        mq.delete();
        m_inflight = 0;
        m_halted = 0;
        d_live = 0;
    end

    task automatic cyc(input bit req, input int a, input bit fl, input bit rdy);
        @(posedge Clk);
        #1;
        FetchReq = req; FetchAddr = L'(a); Flush = fl; InstReady = rdy;
        @(negedge Clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int a = 0; a < 1024; a++) begin
            logic [W-1:0] v;
            v = W'(a) ^ 9'h0A5;
            rom[a] = (v == HALT_OP) ? '0 : v;
        end
        repeat (2) @(posedge Clk);
        #1 Reset = 1'b1;

        // Test 1: streaming fetch, one instruction per cycle.
        for (int i = 0; i < 6; i++) begin
            cyc(i < 4, i, 0, 1);
            chk("t1_stall", 32'(FetchStall), 0);
            chk("t1_valid", 32'(InstValid), 32'(i >= 2));
            if (i >= 2) begin
                chk("t1_pc", 32'(InstPC), 32'(i - 2));
                chk("t1_inst", 32'(InstOut), 32'(9'(i - 2) ^ 9'h0A5));
            end
        end

        // Test 2: back-pressure with InstReady low.
        cyc(1, 5, 0, 0); chk("t2_romen5", 32'(RomEn), 1);
        cyc(1, 6, 0, 0); chk("t2_romen6", 32'(RomEn), 1);
        cyc(1, 7, 0, 0); chk("t2_stall7", 32'(FetchStall), 1); chk("t2_pc_a", 32'(InstPC), 5);
        cyc(1, 7, 0, 0); chk("t2_stall7b", 32'(FetchStall), 1); chk("t2_pc_b", 32'(InstPC), 5);
        cyc(1, 7, 0, 1); chk("t2_romen7", 32'(RomEn), 1); chk("t2_pc_c", 32'(InstPC), 5);
        cyc(0, 0, 0, 1); chk("t2_pc6", 32'(InstPC), 6);
        cyc(0, 0, 0, 1); chk("t2_pc7", 32'(InstPC), 7);
        cyc(0, 0, 0, 1); chk("t2_empty", 32'(InstValid), 0);

        // Test 3: flush kills queued and in-flight work.
        got.delete();
        cyc(1, 5, 0, 0);
        cyc(1, 6, 0, 0);
        cyc(1, 7, 1, 0); chk("t3_valid", 32'(InstValid), 0); chk("t3_romen", 32'(RomEn), 0);
        cyc(1, 'h40, 0, 1); chk("t3_romen40", 32'(RomEn), 1); chk("t3_v1", 32'(InstValid), 0);
        cyc(0, 0, 0, 1); chk("t3_v2", 32'(InstValid), 0);
        cyc(0, 0, 0, 1); chk("t3_pc40", 32'(InstPC), 'h40); chk("t3_v3", 32'(InstValid), 1);
        cyc(0, 0, 0, 1);
        chk("t3_ndeliv", 32'(got.size()), 1);
        if (got.size() == 1) chk("t3_deliv", 32'(got[0]), 'h40);

        // Test 4: asynchronous reset mid-cycle with a full queue.
        cyc(1, 8, 0, 0);
        cyc(1, 9, 0, 0);
        cyc(1, 10, 0, 0);
        @(posedge Clk);
        #2;
        chk("t4_pre_valid", 32'(InstValid), 1);
        chk("t4_pre_stall", 32'(FetchStall), 1);
        #1 Reset = 1'b0;
        #1;
        chk("t4_valid", 32'(InstValid), 0);
        chk("t4_romen", 32'(RomEn), 0);
        chk("t4_stall", 32'(FetchStall), 0);
        @(posedge Clk);
        #1 Reset = 1'b1; FetchReq = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc(i < 4, 'h10 + i, 0, 1);
            chk("t4_stall_r", 32'(FetchStall), 0);
            chk("t4_valid_r", 32'(InstValid), 32'(i >= 2));
            if (i >= 2) chk("t4_pc", 32'(InstPC), 32'('h10 + i - 2));
        end

`ifdef FETCH_HALT_DETECT_EN
        // Test 5: halt instruction at address 3.
        rom[3] = HALT_OP;
        got.delete();
        for (int i = 0; i < 6; i++) begin
            cyc(1, i, 0, 1);
            if (i == 4) begin
                chk("t5_stall4", 32'(FetchStall), 1);
                chk("t5_romen4", 32'(RomEn), 0);
            end
            if (i == 5) begin
                chk("t5_halted", 32'(Halted), 1);
                chk("t5_stall5", 32'(FetchStall), 1);
            end
        end
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        chk("t5_ndeliv", 32'(got.size()), 4);
        for (int k = 0; k < 4 && k < got.size(); k++) chk("t5_deliv", 32'(got[k]), 32'(k));
        cyc(0, 0, 1, 1);
        cyc(0, 0, 0, 1);
        chk("t5_unhalt", 32'(Halted), 0);
        chk("t5_unstall", 32'(FetchStall), 0);
        rom[3] = 9'(3) ^ 9'h0A5;
`endif

        // Test 6: steady push+pop across pointer wrap, 10 instructions.
        got.delete();
        for (int i = 0; i < 12; i++) begin
            cyc(i < 10, 20 + i, 0, 1);
            if (i >= 2) chk("t6_valid", 32'(InstValid), 1);
            chk("t6_stall", 32'(FetchStall), 0);
        end
        cyc(0, 0, 0, 1);
        chk("t6_ndeliv", 32'(got.size()), 10);
        for (int k = 0; k < 10 && k < got.size(); k++) chk("t6_order", 32'(got[k]), 32'(20 + k));

        // Mixed directed pattern; checked cycle by cycle against the model.
        for (int i = 0; i < 40; i++) begin
            cyc((i % 5) != 4, 100 + i, (i == 17) || (i == 31), (i % 3) != 0);
        end
        repeat (4) cyc(0, 0, 0, 1);
        chk("end_empty", 32'(InstValid), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
